// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for the seven-segment scan controller: scan control and load
// inputs plus the registered anode/decoder outputs and status pulses.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              nibble_out;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    load_ack;
  logic                    frame_done;

  modport master (
    output en, load, value, blank_mask,
    input  nibble_out, an_n, load_ack, frame_done
  );

  modport slave (
    input  en, load, value, blank_mask,
    output nibble_out, an_n, load_ack, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with dead time
// and frame-aligned double buffering. Optional macro SEG_SCAN_LZ_BLANK_EN
// enables leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int MAX_CYC = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int VAL_W   = 4 * NUM_DIGITS;

  typedef enum logic {S_DEAD, S_DRIVE} state_t;

  state_t                r_state, w_state;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [VAL_W-1:0]      r_shadow, w_shadow;
  logic [VAL_W-1:0]      r_pend, w_pend;
  logic                  r_pend_vld, w_pend_vld;
  logic [NUM_DIGITS-1:0] r_an_n, w_an_n;
  logic [3:0]            r_nibble, w_nibble;
  logic                  r_load_ack, w_load_ack;
  logic                  r_frame_done, w_frame_done;
  logic                  w_boundary;
  logic [NUM_DIGITS-1:0] w_dark;

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic w_hi_zero;

  // Digit 0 is excluded so an all-zero value still shows a single "0".
  always_comb begin
    w_dark    = '0;
    w_hi_zero = 1'b1;
    for (int d = NUM_DIGITS - 1; d > 0; d--) begin
      w_hi_zero = w_hi_zero & (r_shadow[4*d +: 4] == 4'd0);
      w_dark[d] = w_hi_zero;
    end
  end
`else
  assign w_dark = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_DEAD;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_an_n       <= '1;
      r_nibble     <= 4'd0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_shadow     <= w_shadow;
      r_pend       <= w_pend;
      r_pend_vld   <= w_pend_vld;
      r_an_n       <= w_an_n;
      r_nibble     <= w_nibble;
      r_load_ack   <= w_load_ack;
      r_frame_done <= w_frame_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_shadow     = r_shadow;
    w_pend       = r_pend;
    w_pend_vld   = r_pend_vld;
    w_load_ack   = 1'b0;
    w_frame_done = 1'b0;
    w_boundary   = 1'b0;
    w_an_n       = '1;
    w_nibble     = 4'd0;

    if (!bus.en) begin
      w_state = S_DEAD;
      w_idx   = '0;
      w_cnt   = '0;
    end else begin
      case (r_state)
        S_DEAD: begin
          if (r_cnt == CNT_W'(DEAD_CYC - 1)) begin
            w_state = S_DRIVE;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        S_DRIVE: begin
          if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            w_state = S_DEAD;
            w_cnt   = '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
              w_idx      = '0;
              w_boundary = 1'b1;
            end else begin
              w_idx = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state = S_DEAD;
          w_cnt   = '0;
        end
      endcase
    end

    // A load coinciding with the boundary bypasses the pending register.
    if (w_boundary) begin
      w_frame_done = 1'b1;
      if (bus.load) begin
        w_shadow   = bus.value;
        w_pend_vld = 1'b0;
        w_load_ack = 1'b1;
      end else if (r_pend_vld) begin
        w_shadow   = r_pend;
        w_pend_vld = 1'b0;
        w_load_ack = 1'b1;
      end
    end else if (bus.load) begin
      w_pend     = bus.value;
      w_pend_vld = 1'b1;
    end

    w_nibble = w_shadow[{w_idx, 2'b00} +: 4];
    if (w_state == S_DRIVE)
      w_an_n[w_idx] = bus.blank_mask[w_idx] | w_dark[w_idx];
  end

  assign bus.nibble_out = r_nibble;
  assign bus.an_n       = r_an_n;
  assign bus.load_ack   = r_load_ack;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts every
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_seg_scan_ctrl;
  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int DC    = 2;
  localparam int PER   = DC + RD;
  localparam int FRAME = ND * PER;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [3:0]    nib;
    logic          ack;
    logic          fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus();

  seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .DEAD_CYC   (DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  exp_t          sb_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            n_ack  = 0;
  int            m_pos  = 0;
  logic [15:0]   m_shadow = '0;
  logic [15:0]   m_pend   = '0;
  logic          m_pv     = 1'b0;
  logic [ND-1:0] cur_mask = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [15:0] v, input int d);
    return v[d*4 +: 4];
  endfunction

  task automatic step(input logic r, input logic e, input logic ld,
                      input logic [15:0] v, input logic [ND-1:0] mk);
    exp_t          x;
    exp_t          got;
    int            d;
    logic          bnd;
    logic          allz;
    logic [ND-1:0] dark;
    rst_n          = r;
    bus.en         = e;
    bus.load       = ld;
    bus.value      = v;
    bus.blank_mask = mk;
    x.ack = 1'b0;
    x.fd  = 1'b0;
    if (!r) begin
      m_pos = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0;
    end else if (!e) begin
      m_pos = 0;
      if (ld) begin m_pend = v; m_pv = 1'b1; end
    end else begin
      bnd   = (m_pos == FRAME - 1);
      m_pos = (m_pos + 1) % FRAME;
      if (bnd) begin
        x.fd = 1'b1;
        if (ld) begin
          m_shadow = v; m_pv = 1'b0; x.ack = 1'b1;
        end else if (m_pv) begin
          m_shadow = m_pend; m_pv = 1'b0; x.ack = 1'b1;
        end
      end else if (ld) begin
        m_pend = v; m_pv = 1'b1;
      end
    end
    d    = m_pos / PER;
    dark = '0;
    allz = 1'b1;
`ifdef SEG_SCAN_LZ_BLANK_EN
    for (int k = ND - 1; k > 0; k--) begin
      allz    = allz & (nib_of(m_shadow, k) == 4'd0);
      dark[k] = allz;
    end
`endif
    x.an = '1;
    if (r && e && (m_pos % PER) >= DC && !mk[d] && !dark[d]) x.an[d] = 1'b0;
    x.nib = nib_of(m_shadow, d);
    sb_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk("an_n",       32'(bus.an_n),       32'(got.an));
      chk("nibble_out", 32'(bus.nibble_out), 32'(got.nib));
      chk("load_ack",   32'(bus.load_ack),   32'(got.ack));
      chk("frame_done", 32'(bus.frame_done), 32'(got.fd));
      if (bus.load_ack) n_ack++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 16'h0, cur_mask);
  endtask

  task automatic goto_pos(input int p);
    for (int i = 0; i <= FRAME && m_pos != p; i++) step(1'b1, 1'b1, 1'b0, 16'h0, cur_mask);
    chk("goto_pos", 32'(m_pos), 32'(p));
  endtask

  int a0;

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0, '0);
    idle(FRAME + 2);

    // Mid-frame load is held back until the frame boundary.
    goto_pos(5);
    a0 = n_ack;
    step(1'b1, 1'b1, 1'b1, 16'h1234, cur_mask);
    idle(2 * FRAME);
    chk("ack_1234", 32'(n_ack - a0), 32'd1);

    // Two loads in one frame: last wins, one acknowledge.
    goto_pos(3);
    a0 = n_ack;
    step(1'b1, 1'b1, 1'b1, 16'hAAAA, cur_mask);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 16'h5555, cur_mask);
    idle(2 * FRAME);
    chk("ack_double", 32'(n_ack - a0), 32'd1);

    // Load on the boundary edge itself.
    goto_pos(FRAME - 1);
    step(1'b1, 1'b1, 1'b1, 16'h9876, cur_mask);
    chk("bypass_shadow", 32'(m_shadow), 32'h9876);
    idle(FRAME);

    cur_mask = 4'b0100;
    idle(FRAME + 3);
    cur_mask = 4'b0000;

    // Disable during digit 2 drive; load while disabled waits for a real boundary.
    goto_pos(2 * PER + DC + 1);
    step(1'b1, 1'b0, 1'b0, 16'h0, cur_mask);
    step(1'b1, 1'b0, 1'b1, 16'h4321, cur_mask);
    idle(0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, cur_mask);
    idle(2 * FRAME);

    // Reset mid-drive discards pending data.
    step(1'b1, 1'b1, 1'b1, 16'hBEEF, cur_mask);
    goto_pos(PER + DC + 1);
    step(1'b0, 1'b1, 1'b0, 16'h0, cur_mask);
    idle(FRAME + 2);

    goto_pos(10);
    step(1'b1, 1'b1, 1'b1, 16'h0070, cur_mask);
    idle(2 * FRAME);
    step(1'b1, 1'b1, 1'b1, 16'h0000, cur_mask);
    idle(2 * FRAME);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) cur_mask = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 7) == 0), 16'($urandom), cur_mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits that share one combinational 4-bit-to-7-segment decoder.
- Sequences digit selection and feeds the shared decoder one nibble at a time.
- Inserts all-off dead time between digits to prevent ghosting.
- Double-buffers the displayed value so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal 2..8.
- REFRESH_DIV, 50000, clock cycles each digit is driven (DRIVE state); must be >= 1.
- DEAD_CYC, 2, clock cycles with all anodes off before each digit (DEAD state); must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable; 0 blanks the display.
- load  input  1  request to update the displayed value.
- value  input  4*NUM_DIGITS  new digit nibbles; digit 0 = value[3:0].
- blank_mask  input  NUM_DIGITS  1 = force digit off; sampled live.
- nibble_out  output  4  nibble to the shared decoder input (registered).
- an_n  output  NUM_DIGITS  active-low anode enables (registered).
- load_ack  output  1  one-cycle pulse when the pending value becomes displayed.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
- Reset values:
  - an_n = all 1, nibble_out = 0, load_ack = 0, frame_done = 0.
  - Shadow register = 0, pending register = 0, pending flag = 0.
  - Digit index = 0, cycle counter = 0, state = DEAD.
- Reset asserted mid-frame or mid-load aborts everything. Any pending value is discarded.
- States:
  - DEAD: an_n all 1. nibble_out = shadow nibble of the current index. Lasts DEAD_CYC cycles, then goes to DRIVE with the counter reset.
  - DRIVE: an_n[idx] = 0 unless blank_mask[idx] = 1; all other bits 1. Lasts REFRESH_DIV cycles, then goes to DEAD.
- Index advance: on DRIVE->DEAD, idx increments. From NUM_DIGITS-1 it wraps to 0; this wrap is the frame boundary.
- Timing:
  - nibble_out and an_n are registered together, so the decoder output is valid for the whole DRIVE window.
  - nibble_out is updated on entry to DEAD, giving the decoder the dead time to settle.
- Load handshake:
  - load = 1 at an edge captures value into the pending register and sets the pending flag.
  - A repeated load before the boundary overwrites pending (last wins).
  - At the frame boundary edge with the pending flag set: shadow <= pending, flag cleared, load_ack = 1 for that next cycle.
  - If load = 1 on the boundary edge itself: value bypasses pending and goes straight to shadow, and load_ack pulses.
  - load_ack never pulses without a transfer.
- frame_done: pulses one cycle after every boundary, regardless of load activity.
- Disable: en = 0 at an edge forces state DEAD, idx 0, counter 0 and an_n all 1 on the next cycle, with no frame_done.
  - Loads are still captured while disabled, but transfer only at a real boundary.
  - On en returning to 1, scanning restarts at digit 0 with a full DEAD period.
- Counter width: $clog2 of max(REFRESH_DIV, DEAD_CYC)+1. The counter must never wrap inside a state.
- Periods: per-digit period = DEAD_CYC + REFRESH_DIV cycles; frame period = NUM_DIGITS times that.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. A digit whose shadow nibble is 0 and whose more-significant digits are all 0 is held dark (an_n bit stays 1) during its DRIVE.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Computed from the shadow register only; it changes only at frame boundaries.
- Not defined: no suppression; only blank_mask darkens digits.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=2):
- Reset: hold rst_n = 0 for 3 cycles, release with en = 1 -> an_n = 4'b1111 for 2 cycles, then 4'b1110 for 4 cycles. Frame period = 24 cycles; frame_done every 24 cycles.
- Load value = 16'h1234 mid-frame -> displayed nibbles unchanged until the boundary. load_ack pulses once with frame_done. Next frame nibble_out sequence = 4, 3, 2, 1 aligned with an_n 1110, 1101, 1011, 0111.
- Two loads (16'hAAAA, then 16'h5555) in one frame -> only 16'h5555 displayed; exactly one load_ack. Load on the boundary edge -> shown in the immediately following frame.
- blank_mask = 4'b0100 -> an_n never equals 4'b1011. Timing and frame_done are unchanged.
- en dropped during digit 2 DRIVE -> an_n = 4'b1111 next cycle. Re-enable -> 2 DEAD cycles, then digit 0. Reset asserted mid-DRIVE -> all outputs return to reset values on the next edge.
- SEG_SCAN_LZ_BLANK_EN defined:
  - value = 16'h0070 -> digits 3 and 2 dark, digits 1 and 0 driven.
  - value = 16'h0000 -> only digit 0 driven.
